// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone subordinate among NUM_MANAGERS managers.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that aborts a stalled grant with an error.
module wishbone_rr_arbiter #(
  parameter  int NUM_MANAGERS   = 4,
  parameter  int ADR_W          = 32,
  parameter  int DAT_W          = 32,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int SW             = DAT_W / 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_MANAGERS*ADR_W-1:0] A_ADR_I,
  input  logic [NUM_MANAGERS*DAT_W-1:0] A_DAT_I,
  input  logic [NUM_MANAGERS*SW-1:0]    A_SEL_I,
  input  logic [NUM_MANAGERS-1:0]       A_WE_I,
  input  logic [NUM_MANAGERS-1:0]       A_STB_I,
  input  logic [NUM_MANAGERS-1:0]       A_CYC_I,
  output logic [NUM_MANAGERS*DAT_W-1:0] A_DAT_O,
  output logic [NUM_MANAGERS-1:0]       A_ACK_O,
  output logic [NUM_MANAGERS-1:0]       A_ERR_O,
  input  logic [DAT_W-1:0]              DAT_I,
  input  logic                          ACK_I,
  input  logic                          ERR_I,
  output logic [ADR_W-1:0]              ADR_O,
  output logic [DAT_W-1:0]              DAT_O,
  output logic [SW-1:0]                 SEL_O,
  output logic                          WE_O,
  output logic                          STB_O,
  output logic                          CYC_O,
  output logic [NUM_MANAGERS-1:0]       GNT_O
);

  localparam int IDX_W = $clog2(NUM_MANAGERS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [IDX_W-1:0]        ptr_reg, ptr_next;
  logic [NUM_MANAGERS-1:0] gnt_reg, gnt_next;

  logic [NUM_MANAGERS-1:0] req;
  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W:0]          cand;
  logic [IDX_W-1:0]        ptr_wrap;
  logic                    timeout;

  logic [ADR_W-1:0]        g_adr;
  logic [DAT_W-1:0]        g_dat;
  logic [SW-1:0]           g_sel;
  logic                    g_we;
  logic                    g_stb;
  logic                    g_cyc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MANAGERS; gi++) begin : g_req
      assign req[gi] = A_CYC_I[gi] & A_STB_I[gi];
    end
  endgenerate

  // Signals of the currently granted manager; only meaningful while in GRANT.
  assign g_adr = A_ADR_I[idx_reg*ADR_W +: ADR_W];
  assign g_dat = A_DAT_I[idx_reg*DAT_W +: DAT_W];
  assign g_sel = A_SEL_I[idx_reg*SW +: SW];
  assign g_we  = A_WE_I[idx_reg];
  assign g_stb = A_STB_I[idx_reg];
  assign g_cyc = A_CYC_I[idx_reg];

  // Scan requesters starting at the pointer, wrapping modulo NUM_MANAGERS.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_reg;
    cand       = '0;
    for (int k = 0; k < NUM_MANAGERS; k++) begin
      cand = {1'b0, ptr_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_MANAGERS)) begin
        cand = cand - (IDX_W+1)'(NUM_MANAGERS);
      end
      if (!pick_found && req[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign ptr_wrap = (idx_reg == IDX_W'(NUM_MANAGERS - 1)) ? '0 : idx_reg + 1'b1;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WD_W = 16;

  logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic            waiting;

  assign waiting = (state_reg == GRANT) && g_stb && !ACK_I && !ERR_I;
  assign timeout = waiting && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_next = wd_cnt_reg;
    if ((state_reg != GRANT) || ACK_I || ERR_I || timeout || !g_cyc) begin
      wd_cnt_next = '0;
    end else if (g_stb) begin
      wd_cnt_next = wd_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_next;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
          idx_next   = pick_idx;
          gnt_next   = NUM_MANAGERS'(1) << pick_idx;
        end
      end
      GRANT: begin
        // The grant is held for as long as the owner keeps CYC asserted.
        if (!g_cyc || timeout) begin
          state_next = IDLE;
          ptr_next   = ptr_wrap;
          gnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    ADR_O = '0;
    DAT_O = '0;
    SEL_O = '0;
    WE_O  = 1'b0;
    STB_O = 1'b0;
    CYC_O = 1'b0;
    if (state_reg == GRANT) begin
      ADR_O = g_adr;
      DAT_O = g_dat;
      SEL_O = g_sel;
      WE_O  = g_we;
      STB_O = g_stb & ~timeout;
      CYC_O = g_cyc & ~timeout;
    end
  end

  // gnt_reg is one-hot exactly when in GRANT, so it doubles as the return-path select.
  generate
    for (gi = 0; gi < NUM_MANAGERS; gi++) begin : g_ret
      assign A_DAT_O[gi*DAT_W +: DAT_W] = gnt_reg[gi] ? DAT_I : '0;
      assign A_ACK_O[gi]                = gnt_reg[gi] & ACK_I;
      assign A_ERR_O[gi]                = gnt_reg[gi] & (ERR_I | timeout);
    end
  endgenerate

  assign GNT_O = gnt_reg;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Bench for wishbone_rr_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbitration rules.
module tb_wishbone_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST;
  logic [N*AW-1:0] a_adr;
  logic [N*DW-1:0] a_dat;
  logic [N*SW-1:0] a_sel;
  logic [N-1:0]    a_we, a_stb, a_cyc;
  logic [N*DW-1:0] a_dat_o;
  logic [N-1:0]    a_ack_o, a_err_o;
  logic [DW-1:0]   dat_i;
  logic            ack_i, err_i;
  logic [AW-1:0]   adr_o;
  logic [DW-1:0]   dat_o;
  logic [SW-1:0]   sel_o;
  logic            we_o, stb_o, cyc_o;
  logic [N-1:0]    gnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: owner of the bus (-1 when free), rotation pointer, consecutive stalled beats.
  int m_owner, m_ptr, m_wd;

  wishbone_rr_arbiter #(
    .NUM_MANAGERS(N), .ADR_W(AW), .DAT_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .A_ADR_I(a_adr), .A_DAT_I(a_dat), .A_SEL_I(a_sel),
    .A_WE_I(a_we), .A_STB_I(a_stb), .A_CYC_I(a_cyc),
    .A_DAT_O(a_dat_o), .A_ACK_O(a_ack_o), .A_ERR_O(a_err_o),
    .DAT_I(dat_i), .ACK_I(ack_i), .ERR_I(err_i),
    .ADR_O(adr_o), .DAT_O(dat_o), .SEL_O(sel_o),
    .WE_O(we_o), .STB_O(stb_o), .CYC_O(cyc_o),
    .GNT_O(gnt_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [N-1:0] c, input logic [N-1:0] s, input logic a, input logic e);
    a_cyc = c;
    a_stb = s;
    ack_i = a;
    err_i = e;
    for (int i = 0; i < N; i++) begin
      a_adr[i*AW +: AW] = $urandom;
      a_dat[i*DW +: DW] = $urandom;
      a_sel[i*SW +: SW] = SW'($urandom);
      a_we[i]           = 1'($urandom);
    end
    dat_i = $urandom;
  endtask

  // One clock: check outputs against the model mid-low-phase, then advance the model.
  task automatic step();
    int              o;
    int              idx;
    logic            tmo;
    logic [N-1:0]    e_gnt, e_ack, e_err;
    logic [N*DW-1:0] e_adat;
    logic [AW-1:0]   e_adr;
    logic [DW-1:0]   e_dat;
    logic [SW-1:0]   e_sel;
    logic            e_we, e_stb, e_cyc;
    #1;
    if (RST) begin
      m_owner = -1; m_ptr = 0; m_wd = 0;
    end
    o = m_owner;
    tmo = WD_EN && (o >= 0) && a_stb[o] && !ack_i && !err_i && (m_wd == TO - 1);
    e_gnt = '0; e_ack = '0; e_err = '0; e_adat = '0;
    e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_stb = 1'b0; e_cyc = 1'b0;
    if (o >= 0) begin
      e_gnt[o]             = 1'b1;
      e_ack[o]             = ack_i;
      e_err[o]             = err_i | tmo;
      e_adat[o*DW +: DW]   = dat_i;
      e_adr                = a_adr[o*AW +: AW];
      e_dat                = a_dat[o*DW +: DW];
      e_sel                = a_sel[o*SW +: SW];
      e_we                 = a_we[o];
      e_stb                = a_stb[o] & ~tmo;
      e_cyc                = a_cyc[o] & ~tmo;
    end
    chk("gnt", gnt_o, e_gnt);
    chk("adr", adr_o, e_adr);
    chk("dat", dat_o, e_dat);
    chk("sel", sel_o, e_sel);
    chk("we", we_o, e_we);
    chk("stb", stb_o, e_stb);
    chk("cyc", cyc_o, e_cyc);
    chk("a_dat", a_dat_o, e_adat);
    chk("a_ack", a_ack_o, e_ack);
    chk("a_err", a_err_o, e_err);
    @(posedge CLK);
    if (RST) begin
      m_owner = -1; m_ptr = 0; m_wd = 0;
    end else if (o < 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (a_cyc[idx] && a_stb[idx]) begin
          m_owner = idx;
          break;
        end
      end
    end else if (tmo || !a_cyc[o]) begin
      m_ptr = (o + 1) % N; m_owner = -1; m_wd = 0;
    end else if (ack_i || err_i) begin
      m_wd = 0;
    end else if (a_stb[o]) begin
      m_wd++;
    end
    @(negedge CLK);
  endtask

  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [N-1:0] one_k;
    m_owner = -1; m_ptr = 0; m_wd = 0;
    RST = 1'b1;
    drv(4'hF, 4'hF, 1'b0, 1'b0);
    @(negedge CLK);

    // Reset with everyone requesting, then release.
    step();
    step();
    RST = 1'b0;
    drv(4'hF, 4'hF, 1'b0, 1'b0);
    step();
    chk("rst_release_gnt", gnt_o, 4'b0001);

    // Round robin from a fresh pointer.
    RST = 1'b1;
    drv(4'h0, 4'h0, 1'b0, 1'b0);
    step();
    RST = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      one_k = 4'b0001 << rr_exp[k];
      drv(4'hF, 4'hF, 1'b0, 1'b0);
      step();
      chk("rr_order", gnt_o, one_k);
      drv(4'hF, 4'hF, 1'b1, 1'b0);
      step();
      drv(4'hF & ~one_k, 4'hF, 1'b0, 1'b0);
      step();
    end

    // Burst: manager 2 keeps CYC through four acks while manager 1 waits.
    drv(4'b0100, 4'b0100, 1'b0, 1'b0);
    step();
    chk("burst_gnt", gnt_o, 4'b0100);
    for (int k = 0; k < 4; k++) begin
      drv(4'b0110, 4'b0110, 1'b1, 1'b0);
      step();
      chk("burst_hold", gnt_o, 4'b0100);
    end
    drv(4'b0010, 4'b0010, 1'b0, 1'b0);
    step();
    chk("burst_idle", gnt_o, 4'b0000);
    drv(4'b0010, 4'b0010, 1'b0, 1'b0);
    step();
    chk("burst_next", gnt_o, 4'b0010);

    // Return-path routing to manager 3; acks seen while idle go nowhere.
    drv(4'h0, 4'h0, 1'b0, 1'b0);
    step();
    drv(4'h0, 4'h0, 1'b1, 1'b1);
    step();
    drv(4'b1000, 4'b1000, 1'b0, 1'b0);
    a_we[3] = 1'b0;
    step();
    drv(4'b1000, 4'b1000, 1'b1, 1'b0);
    a_we[3] = 1'b0;
    dat_i = 32'hDEADBEEF;
    #1;
    chk("route_dat", a_dat_o, {32'hDEADBEEF, 96'h0});
    chk("route_ack", a_ack_o, 4'b1000);
    step();
    drv(4'b1000, 4'b1000, 1'b0, 1'b1);
    #1;
    chk("route_err", a_err_o, 4'b1000);
    chk("route_err_noack", a_ack_o, 4'b0000);
    step();
    drv(4'b1000, 4'b1000, 1'b1, 1'b1);
    step();

    // Stalled grant to manager 1.
    drv(4'h0, 4'h0, 1'b0, 1'b0);
    step();
    drv(4'b0010, 4'b0010, 1'b0, 1'b0);
    step();
`ifdef WB_ARB_TIMEOUT_EN
    for (int w = 1; w < TO; w++) begin
      drv(4'b0010, 4'b0010, 1'b0, 1'b0);
      #1;
      chk("to_wait_err", a_err_o, 4'b0000);
      step();
    end
    drv(4'b0010, 4'b0010, 1'b0, 1'b0);
    #1;
    chk("to_err_pulse", a_err_o, 4'b0010);
    chk("to_stb_low", stb_o, 1'b0);
    chk("to_cyc_low", cyc_o, 1'b0);
    step();
    chk("to_idle", gnt_o, 4'b0000);
    drv(4'hF, 4'hF, 1'b0, 1'b0);
    step();
    chk("to_ptr_adv", gnt_o, 4'b0100);
`else
    for (int w = 0; w < 20; w++) begin
      drv(4'b0010, 4'b0010, 1'b0, 1'b0);
      step();
      chk("no_to_hold", gnt_o, 4'b0010);
    end
`endif

    // Reset mid-transaction aborts at once and restarts rotation at 0.
    drv(4'hF, 4'hF, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    chk("async_rst_gnt", gnt_o, 4'b0000);
    chk("async_rst_stb", stb_o, 1'b0);
    step();
    RST = 1'b0;
    step();
    chk("post_rst_gnt", gnt_o, 4'b0001);

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      logic [N-1:0] c, s;
      for (int i = 0; i < N; i++) begin
        c[i] = ($urandom_range(0, 3) != 0);
        s[i] = ($urandom_range(0, 3) != 0);
      end
      drv(c, s, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      RST = ($urandom_range(0, 96) == 0);
      step();
    end
    RST = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wishbone_rr_arbiter.md
WISHBONE_RR_ARBITER -- requirements
Module: wishbone_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MANAGERS, default 4, number of requesting managers (2..16).
REQ-002 SHALL have parameter ADR_W, default 32, address width.
REQ-003 SHALL have parameter DAT_W, default 32, data width (multiple of 8); SEL width SW = DAT_W/8.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit (1..65535).
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 CLK  in  1  clock; all state changes on rising edge.
REQ-007 RST  in  1  reset, asynchronous assert, active-high.
REQ-008 A_ADR_I  in  NUM_MANAGERS x ADR_W  per-manager address.
REQ-009 A_DAT_I  in  NUM_MANAGERS x DAT_W  per-manager write data.
REQ-010 A_SEL_I  in  NUM_MANAGERS x SW  per-manager byte select.
REQ-011 A_WE_I / A_STB_I / A_CYC_I  in  NUM_MANAGERS each  per-manager write enable, strobe, cycle.
REQ-012 A_DAT_O  out  NUM_MANAGERS x DAT_W  read data to managers.
REQ-013 A_ACK_O / A_ERR_O  out  NUM_MANAGERS each  per-manager acknowledge, error.
REQ-014 DAT_I  in  DAT_W  read data from subordinate.
REQ-015 ACK_I / ERR_I  in  1 each  subordinate acknowledge, error.
REQ-016 ADR_O / DAT_O / SEL_O  out  ADR_W / DAT_W / SW  routed address, write data, select.
REQ-017 WE_O / STB_O / CYC_O  out  1 each  routed write enable, strobe, cycle.
REQ-018 GNT_O  out  NUM_MANAGERS  registered one-hot current grant; all-zero in IDLE.

Function
REQ-019 Request from manager i SHALL be A_CYC_I[i] && A_STB_I[i].
REQ-020 States SHALL be IDLE and GRANT; grant index and round-robin pointer PTR are registered.
REQ-021 In IDLE all subordinate-side outputs and all A_* outputs SHALL be zero (no combinational pass-through).
REQ-022 In IDLE with any request, SHALL grant first requester at index >= PTR, wrapping modulo NUM_MANAGERS; GRANT entered next edge (1-cycle arbitration latency).
REQ-023 In GRANT, ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O SHALL equal granted manager's inputs; DAT_I, ACK_I, ERR_I SHALL route only to granted manager's A_DAT_O/A_ACK_O/A_ERR_O; others zero.
REQ-024 Grant SHALL be held across multiple ACKs while granted A_CYC_I stays high (burst/locked cycles); requests from others ignored.
REQ-025 When granted A_CYC_I is low in GRANT, SHALL return to IDLE next edge and set PTR = (granted index + 1) mod NUM_MANAGERS.
REQ-026 ACK_I or ERR_I seen while in IDLE SHALL be ignored.
REQ-027 Simultaneous ACK_I and ERR_I SHALL both be forwarded unchanged.
REQ-028 GNT_O SHALL remain one-hot or zero at all times.

Reset
REQ-029 On RST high: state IDLE, PTR = 0, GNT_O = 0, all outputs zero, watchdog counter 0, within the same cycle (asynchronous).
REQ-030 Reset asserted mid-transaction SHALL abort the grant; first request after release arbitrates from PTR = 0.

Configuration
REQ-031 Macro WB_ARB_TIMEOUT_EN SHALL enable a watchdog; without it, no counter exists and GRANT is left only per REQ-025.
REQ-032 With WB_ARB_TIMEOUT_EN: counter increments each GRANT cycle with STB_O high and no ACK_I/ERR_I, clears on ACK_I/ERR_I or IDLE; at TIMEOUT_CYCLES, SHALL pulse A_ERR_O of granted manager for one cycle, force STB_O/CYC_O low that cycle, return to IDLE with PTR advanced per REQ-025.

Verification
REQ-033 Reset: RST=1 with all managers requesting -> all outputs 0, GNT_O=0; release -> manager 0 granted after 1 cycle, GNT_O=4'b0001.
REQ-034 Round robin: managers 0..3 request continuously, each single-beat then dropping CYC for one cycle -> grant order 0,1,2,3,0.
REQ-035 Burst: manager 2 holds CYC for 4 ACKs while manager 1 requests -> GNT_O=4'b0100 throughout; manager 1 granted only after CYC drop.
REQ-036 Routing: manager 3 read, DAT_I=32'hDEADBEEF with ACK_I -> A_DAT_O[3]=32'hDEADBEEF, A_ACK_O=4'b1000, other A_DAT_O zero; ERR_I instead -> A_ERR_O=4'b1000.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=8): manager 1 granted, no ACK -> A_ERR_O[1] pulses on 8th waiting cycle, STB_O=0 that cycle, IDLE next, PTR=2; macro off -> grant held indefinitely.
